prio_arb: RTL and testbench
===========================

PRIO_ARB -- requirements
Module: prio_arb

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of requesters, legal range 2..64, with non-power-of-2 values allowed.
REQ-002 The block SHALL have parameter CW, default 16, meaning the width of the accepted-grant counter.
REQ-003 The block SHALL have localparam IW = $clog2(N), meaning the width of the grant index.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N  request vector, bit i = requester i.
REQ-007 rr_mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-008 gnt_valid  output  1  a registered grant is presented.
REQ-009 gnt_ready  input  1  consumer accepts the grant.
REQ-010 gnt_idx  output  IW  index of the granted requester.
REQ-011 gnt_onehot  output  N  one-hot decode of gnt_idx, all zeros when gnt_valid=0.
REQ-012 gnt_count  output  CW  count of accepted grants, saturating.

Function
REQ-013 The output stage SHALL be one register deep, with "load" defined as the condition gnt_valid=0 OR (gnt_valid=1 AND gnt_ready=1).
REQ-014 On load with |req=1: the block SHALL register the winner into gnt_idx/gnt_onehot and set gnt_valid=1 on the next edge, giving a latency of 1 cycle from req to grant.
REQ-015 On load with req=0: the block SHALL set gnt_valid=0 on the next edge and leave gnt_idx unchanged.
REQ-016 When gnt_valid=1 and gnt_ready=0, gnt_idx, gnt_onehot and gnt_valid SHALL hold stable regardless of req or rr_mode, and a dropped request SHALL NOT retract the grant.
REQ-017 In fixed mode (rr_mode=0 at load), the winner SHALL be the lowest set index of req.
REQ-018 In round-robin mode (rr_mode=1 at load), the winner SHALL be the first set bit searching upward from ptr to N-1, then wrapping to 0 up to ptr-1.
REQ-019 ptr SHALL be an internal IW-bit register, updated only on a round-robin load that produces a grant, to (winner+1) with wrap from N-1 to 0 (not 2^IW to 0).
REQ-020 Fixed-mode loads SHALL leave ptr unchanged, and a mode switch SHALL NOT reset ptr.
REQ-021 Acceptance and a new load in the same cycle SHALL be supported back-to-back, sustaining one grant per cycle with gnt_ready held at 1.
REQ-022 gnt_count SHALL increment by 1 on each cycle with gnt_valid=1 and gnt_ready=1, saturating at 2^CW-1 without wrapping.
REQ-023 Invariants: gnt_valid implies the granted request was set at load time; gnt_onehot equals 1<<gnt_idx when gnt_valid=1.

Reset
REQ-024 Asserting rst_n=0 SHALL asynchronously clear gnt_valid=0, gnt_idx=0, gnt_onehot=0, gnt_count=0 and ptr=0.
REQ-025 Reset asserted mid-handshake SHALL drop any pending grant with no acceptance counted, and the first load after release SHALL use ptr=0.

Structure
REQ-026 A shared package prio_pkg SHALL hold the mode encoding constants (PRIO_FIXED=0, PRIO_RR=1) and an index-width helper function.
REQ-027 Sub-module prio_find (combinational, parameter N) SHALL return the found flag and the lowest set index of a vector.
REQ-028 prio_arb SHALL instantiate prio_find twice, once on req masked to bits at or above ptr and once on unmasked req, selecting the masked result when it is found.

Verification
REQ-029 Scenario: N=8, rr_mode=0, req=8'b1010_0100, gnt_ready=1 -> gnt_idx=2, gnt_onehot=8'h04 after 1 cycle, repeating every cycle.
REQ-030 Scenario: N=8, rr_mode=1, req=8'hFF, gnt_ready=1 from reset -> gnt_idx sequence 0,1,...,7,0 on consecutive cycles, with gnt_count=9 after 9 accepts.
REQ-031 Scenario: N=5, rr_mode=1, req=5'b10001 -> grants alternate 0,4,0,4, confirming wrap from index 4 to 0.
REQ-032 Scenario: grant idx=3 presented, gnt_ready=0 for 4 cycles while req changes to 8'h01 -> idx stays 3 and gnt_valid stays 1, and the load after acceptance grants 0.
REQ-033 Scenario: CW=2, req=8'h01, gnt_ready=1 for 6 cycles -> gnt_count saturates at 3.
REQ-034 Scenario: rst_n pulsed low while gnt_valid=1 and gnt_ready=0 -> all outputs 0 immediately, and after release rr_mode=1 with req=8'h80 gives gnt_idx=7 and then ptr=0.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority arbiter slice.
package prio_pkg;

  localparam logic PRIO_FIXED = 1'b0;
  localparam logic PRIO_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_arb_if.sv
// Request/grant bundle between a requester block and the arbiter.
interface prio_arb_if #(
  parameter int N  = 8,
  parameter int CW = 16
);
  import prio_pkg::*;

  localparam int IW = idx_w(N);

  logic [N-1:0]  req;
  logic          rr_mode;
  logic          gnt_valid;
  logic          gnt_ready;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt_onehot;
  logic [CW-1:0] gnt_count;

  modport master (
    output req, rr_mode, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot, gnt_count
  );

  modport slave (
    input  req, rr_mode, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot, gnt_count
  );

endinterface

// File: rtl/prio_find.sv
// Lowest-set-bit finder: reports whether any bit is set and the index of the lowest one.
module prio_find
  import prio_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan downward so the lowest set bit is the last one to write idx.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/prio_arb.sv
// Fixed-priority / round-robin arbiter with a one-deep registered grant stage
// and a saturating accepted-grant counter.
module prio_arb
  import prio_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 16,
  localparam int IW = idx_w(N)
) (
  input  logic       clk,
  input  logic       rst_n,
  prio_arb_if.slave  bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] ptr;
  logic [N-1:0]  masked_req;
  logic          found_m, found_u;
  logic [IW-1:0] idx_m, idx_u;
  logic [IW-1:0] winner;
  logic          load;

  logic          gnt_valid_q;
  logic [IW-1:0] gnt_idx_q;
  logic [N-1:0]  gnt_onehot_q;
  logic [CW-1:0] gnt_count_q;

  // Round-robin search window: only requesters at or above the pointer.
  always_comb begin
    masked_req = '0;
    for (int i = 0; i < N; i++) begin
      masked_req[i] = bus.req[i] && (i >= int'(ptr));
    end
  end

  prio_find #(.N(N)) u_find_masked (
    .vec   (masked_req),
    .found (found_m),
    .idx   (idx_m)
  );

  prio_find #(.N(N)) u_find_all (
    .vec   (bus.req),
    .found (found_u),
    .idx   (idx_u)
  );

  always_comb begin
    winner = idx_u;
    if (bus.rr_mode == PRIO_RR && found_m) begin
      winner = idx_m;
    end
  end

  assign load = !gnt_valid_q || bus.gnt_ready;

  // Grant register: reloads only when empty or being accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      ptr          <= '0;
    end else if (load) begin
      if (found_u) begin
        gnt_valid_q  <= 1'b1;
        gnt_idx_q    <= winner;
        gnt_onehot_q <= N'(1) << winner;
        if (bus.rr_mode == PRIO_RR) begin
          ptr <= (winner == LAST_IDX) ? '0 : winner + IW'(1);
        end
      end else begin
        gnt_valid_q  <= 1'b0;
        gnt_onehot_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_count_q <= '0;
    end else if (gnt_valid_q && bus.gnt_ready && gnt_count_q != CNT_MAX) begin
      gnt_count_q <= gnt_count_q + CW'(1);
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.gnt_count  = gnt_count_q;

endmodule

// File: tb/tb_prio_arb.sv
// Directed bench for prio_arb: an N=8/CW=16 instance and an N=5/CW=2 instance.
module tb_prio_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  prio_arb_if #(.N(8), .CW(16)) bus_a ();
  prio_arb_if #(.N(5), .CW(2))  bus_b ();

  prio_arb #(.N(8), .CW(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  prio_arb #(.N(5), .CW(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] oh, input logic [15:0] cnt);
    check_output({tag, "_valid"},  64'(bus_a.gnt_valid),  64'(v));
    check_output({tag, "_idx"},    64'(bus_a.gnt_idx),    64'(idx));
    check_output({tag, "_onehot"}, 64'(bus_a.gnt_onehot), 64'(oh));
    check_output({tag, "_count"},  64'(bus_a.gnt_count),  64'(cnt));
  endtask

  logic [2:0] rr_exp;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_a.req = '0; bus_a.rr_mode = 1'b0; bus_a.gnt_ready = 1'b0;
    bus_b.req = '0; bus_b.rr_mode = 1'b0; bus_b.gnt_ready = 1'b0;
    #2;
    check_a("reset", 1'b0, 3'd0, 8'h00, 16'd0);
    step();
    rst_n = 1'b1;

    // Fixed priority: lowest set bit wins every cycle.
    bus_a.rr_mode = 1'b0; bus_a.req = 8'b1010_0100; bus_a.gnt_ready = 1'b1;
    step();
    check_a("fixed_c1", 1'b1, 3'd2, 8'h04, 16'd0);
    step();
    check_a("fixed_c2", 1'b1, 3'd2, 8'h04, 16'd1);
    step();
    check_a("fixed_c3", 1'b1, 3'd2, 8'h04, 16'd2);

    // Round-robin from a fresh reset over all-ones requests.
    rst_n = 1'b0;
    #1;
    check_a("rst_pulse", 1'b0, 3'd0, 8'h00, 16'd0);
    bus_a.rr_mode = 1'b1; bus_a.req = 8'hFF; bus_a.gnt_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      rr_exp = 3'(k % 8);
      check_output("rr_idx", 64'(bus_a.gnt_idx), 64'(rr_exp));
      check_output("rr_onehot", 64'(bus_a.gnt_onehot), 64'(8'h01 << rr_exp));
    end
    step();
    check_a("rr_after9", 1'b1, 3'd1, 8'h02, 16'd9);

    // Stall: grant 3 must hold while req and mode change.
    bus_a.rr_mode = 1'b0; bus_a.req = 8'h08;
    step();
    check_a("stall_load", 1'b1, 3'd3, 8'h08, 16'd10);
    bus_a.gnt_ready = 1'b0; bus_a.req = 8'h01; bus_a.rr_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_a("stall_hold", 1'b1, 3'd3, 8'h08, 16'd10);
    end
    bus_a.gnt_ready = 1'b1; bus_a.rr_mode = 1'b0;
    step();
    check_a("stall_release", 1'b1, 3'd0, 8'h01, 16'd11);

    // Reset in the middle of a stalled handshake.
    bus_a.req = 8'h20;
    step();
    check_a("pre_rst_load", 1'b1, 3'd5, 8'h20, 16'd12);
    bus_a.gnt_ready = 1'b0;
    step();
    check_a("pre_rst_hold", 1'b1, 3'd5, 8'h20, 16'd12);
    rst_n = 1'b0;
    #1;
    check_a("mid_rst", 1'b0, 3'd0, 8'h00, 16'd0);
    bus_a.rr_mode = 1'b1; bus_a.req = 8'h80; bus_a.gnt_ready = 1'b0;
    rst_n = 1'b1;
    step();
    check_a("post_rst_7", 1'b1, 3'd7, 8'h80, 16'd0);
    bus_a.req = 8'hFF; bus_a.gnt_ready = 1'b1;
    step();
    check_a("post_rst_wrap", 1'b1, 3'd0, 8'h01, 16'd1);

    // N=5 round-robin wrap and CW=2 counter saturation.
    bus_b.rr_mode = 1'b1; bus_b.req = 5'b10001; bus_b.gnt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      rr_exp = (k % 2 == 0) ? 3'd0 : 3'd4;
      check_output("n5_valid", 64'(bus_b.gnt_valid), 64'd1);
      check_output("n5_idx", 64'(bus_b.gnt_idx), 64'(rr_exp));
      check_output("n5_onehot", 64'(bus_b.gnt_onehot), 64'(5'b00001 << rr_exp));
      check_output("n5_count", 64'(bus_b.gnt_count), (k > 3) ? 64'd3 : 64'(k));
    end
    bus_b.req = 5'b00000;
    step();
    check_output("n5_idle_valid", 64'(bus_b.gnt_valid), 64'd0);
    check_output("n5_idle_idx", 64'(bus_b.gnt_idx), 64'd4);
    check_output("n5_idle_onehot", 64'(bus_b.gnt_onehot), 64'd0);
    check_output("n5_idle_count", 64'(bus_b.gnt_count), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
